// File: rtl/mult_share_ctrl_if.sv
// Requester, result and multiplier-side signals of the shared-multiplier controller.
// The controller attaches through the slave modport; the surrounding system uses master.
interface mult_share_ctrl_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [16*NREQ-1:0] req_a;
  logic [16*NREQ-1:0] req_b;
  logic [15:0]        mul_a;
  logic [15:0]        mul_b;
  logic [31:0]        mul_p;
  logic               res_valid;
  logic               res_ready;
  logic [31:0]        res_p;
  logic [IDW-1:0]     res_id;
  logic               busy;

  modport master (
    output req_valid, req_a, req_b, res_ready, mul_p,
    input  req_ready, mul_a, mul_b, res_valid, res_p, res_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready, mul_p,
    output req_ready, mul_a, mul_b, res_valid, res_p, res_id, busy
  );
endinterface

// File: rtl/mult_share_ctrl.sv
// Round-robin time-sharing controller for one combinational 16x16 multiplier.
// The winner's operands sit in registers for MC_CYCLES cycles before the product is captured.
module mult_share_ctrl #(
  parameter int NREQ      = 4,
  parameter int MC_CYCLES = 2,
  parameter int IDW       = 2
) (
  input  logic             clk,
  input  logic             rst,
  mult_share_ctrl_if.slave bus
);
  localparam int CW = (MC_CYCLES > 1) ? $clog2(MC_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_next_s;
  logic [IDW-1:0]  rr_ptr_r;
  logic [IDW-1:0]  res_id_r;
  logic [IDW-1:0]  grant_idx_s;
  logic [IDW-1:0]  next_ptr_s;
  logic [IDW:0]    off_s;
  logic [IDW:0]    best_off_s;
  logic [CW-1:0]   cnt_r;
  logic [15:0]     op_a_r;
  logic [15:0]     op_b_r;
  logic [15:0]     grant_a_s;
  logic [15:0]     grant_b_s;
  logic [31:0]     res_p_r;
  logic            res_valid_r;
  logic            grant_found_s;
  logic            accept_s;
  logic            sample_s;
  logic            release_s;
  logic [NREQ-1:0] req_ready_s;

  // Winner = valid requester at the smallest circular distance from rr_ptr.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    grant_a_s     = 16'h0000;
    grant_b_s     = 16'h0000;
    best_off_s    = (IDW+1)'(NREQ);
    off_s         = '0;
    for (int i = 0; i < NREQ; i++) begin
      off_s = (IDW+1)'(i) + (IDW+1)'(NREQ) - {1'b0, rr_ptr_r};
      off_s = (off_s >= (IDW+1)'(NREQ)) ? (off_s - (IDW+1)'(NREQ)) : off_s;
      if (bus.req_valid[i] && (off_s < best_off_s)) begin
        grant_found_s = 1'b1;
        best_off_s    = off_s;
        grant_idx_s   = IDW'(i);
        grant_a_s     = bus.req_a[16*i +: 16];
        grant_b_s     = bus.req_b[16*i +: 16];
      end else begin
        best_off_s = best_off_s;
      end
    end
    next_ptr_s = (grant_idx_s == IDW'(NREQ-1)) ? '0 : (grant_idx_s + 1'b1);
  end

  // Next-state and handshake decode.
  always_comb begin
    state_next_s = state_r;
    req_ready_s  = '0;
    accept_s     = 1'b0;
    sample_s     = 1'b0;
    release_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Grant is masked while reset is held so no ready leaks during reset.
        if (grant_found_s && !rst) begin
          req_ready_s  = {{(NREQ-1){1'b0}}, 1'b1} << grant_idx_s;
          accept_s     = 1'b1;
          state_next_s = ST_WAIT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == '0) begin
          sample_s     = 1'b1;
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        if (bus.res_ready) begin
          release_s    = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand hold, multicycle counter, round-robin pointer and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_r    <= '0;
      op_a_r      <= 16'h0000;
      op_b_r      <= 16'h0000;
      cnt_r       <= '0;
      res_p_r     <= 32'h0000_0000;
      res_id_r    <= '0;
      res_valid_r <= 1'b0;
    end else begin
      if (accept_s) begin
        op_a_r   <= grant_a_s;
        op_b_r   <= grant_b_s;
        res_id_r <= grant_idx_s;
        rr_ptr_r <= next_ptr_s;
        cnt_r    <= CW'(MC_CYCLES - 1);
      end else if ((state_r == ST_WAIT) && (cnt_r != '0)) begin
        cnt_r <= cnt_r - 1'b1;
      end
      if (sample_s) begin
        res_p_r     <= bus.mul_p;
        res_valid_r <= 1'b1;
      end else if (release_s) begin
        res_valid_r <= 1'b0;
      end
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.mul_a     = op_a_r;
  assign bus.mul_b     = op_b_r;
  assign bus.res_valid = res_valid_r;
  assign bus.res_p     = res_p_r;
  assign bus.res_id    = res_id_r;
  assign bus.busy      = (state_r != ST_IDLE);
endmodule

// File: tb/tb_mult_share_ctrl.sv
// Self-checking bench for mult_share_ctrl: directed scenarios followed by randomized
// request traffic, all compared against a round-robin reference model kept here.
module tb_mult_share_ctrl;
  localparam int NREQ = 4;
  localparam int MC   = 2;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [15:0]     a_m [NREQ];
  logic [15:0]     b_m [NREQ];
  logic [NREQ-1:0] pend;
  int              ptr_m;
  logic [31:0]     last_p;
  logic [IDW-1:0]  last_id;

  mult_share_ctrl_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  mult_share_ctrl #(.NREQ(NREQ), .MC_CYCLES(MC), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared combinational multiplier.
  assign bus.mul_p = {16'h0000, bus.mul_a} * {16'h0000, bus.mul_b};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // First pending requester walking upward from the model pointer, modulo NREQ.
  function automatic int pick();
    for (int off = 0; off < NREQ; off++) begin
      if (pend[(ptr_m + off) % NREQ]) return (ptr_m + off) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [15:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      default: return 16'($urandom());
    endcase
  endfunction

  task automatic drive();
    bus.req_valid = pend;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[16*i +: 16] = a_m[i];
      bus.req_b[16*i +: 16] = b_m[i];
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    pend = '0;
    ptr_m = 0;
    drive();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One complete operation; caller guarantees pend != 0 and DUT idle.
  task automatic run_op(input int hold, input logic [NREQ-1:0] drop);
    int          g;
    logic [15:0] ga;
    logic [15:0] gb;
    logic [31:0] ep;
    g = pick();
    drive();
    #1;
    chk("grant_ready", {28'h0, bus.req_ready}, 32'd1 << g);
    chk("idle_busy", {31'h0, bus.busy}, 32'd0);
    ga = a_m[g];
    gb = b_m[g];
    ep = {16'h0000, ga} * {16'h0000, gb};
    @(posedge clk);
    pend[g] = 1'b0;
    pend = pend & ~drop;
    ptr_m = (g + 1) % NREQ;
    @(negedge clk);
    drive();
    for (int i = 0; i < MC; i++) begin
      #1;
      chk("wait_valid", {31'h0, bus.res_valid}, 32'd0);
      chk("wait_ready", {28'h0, bus.req_ready}, 32'd0);
      chk("wait_busy", {31'h0, bus.busy}, 32'd1);
      chk("wait_mul_a", {16'h0, bus.mul_a}, {16'h0, ga});
      chk("wait_mul_b", {16'h0, bus.mul_b}, {16'h0, gb});
      @(negedge clk);
    end
    #1;
    chk("res_valid", {31'h0, bus.res_valid}, 32'd1);
    chk("res_p", bus.res_p, ep);
    chk("res_id", {30'h0, bus.res_id}, 32'(g));
    chk("done_ready", {28'h0, bus.req_ready}, 32'd0);
    last_p  = bus.res_p;
    last_id = bus.res_id;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1;
      chk("hold_valid", {31'h0, bus.res_valid}, 32'd1);
      chk("hold_p", bus.res_p, ep);
      chk("hold_id", {30'h0, bus.res_id}, 32'(g));
      chk("hold_ready", {28'h0, bus.req_ready}, 32'd0);
      chk("hold_busy", {31'h0, bus.busy}, 32'd1);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    #1;
    chk("rel_valid", {31'h0, bus.res_valid}, 32'd0);
    chk("rel_busy", {31'h0, bus.busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.res_ready = 1'b0;
    pend = '0;
    ptr_m = 0;
    for (int i = 0; i < NREQ; i++) begin
      a_m[i] = 16'h0000;
      b_m[i] = 16'h0000;
    end
    drive();
    bus.req_valid = '1;
    @(negedge clk);
    #1;
    chk("rst_ready", {28'h0, bus.req_ready}, 32'd0);
    chk("rst_valid", {31'h0, bus.res_valid}, 32'd0);
    chk("rst_busy", {31'h0, bus.busy}, 32'd0);
    chk("rst_p", bus.res_p, 32'd0);
    chk("rst_id", {30'h0, bus.res_id}, 32'd0);
    chk("rst_mul_a", {16'h0, bus.mul_a}, 32'd0);
    chk("rst_mul_b", {16'h0, bus.mul_b}, 32'd0);
    drive();
    @(negedge clk);
    rst = 1'b0;

    // Single requester, 3 * 5.
    a_m[0] = 16'd3;
    b_m[0] = 16'd5;
    pend = 4'b0001;
    run_op(0, 4'b0000);
    chk("tp1_p", last_p, 32'd15);
    chk("tp1_id", {30'h0, last_id}, 32'd0);

    // All four requesting from a fresh pointer: order 0,1,2,3,0.
    pulse_reset();
    for (int i = 0; i < NREQ; i++) begin
      a_m[i] = 16'(i + 1);
      b_m[i] = 16'h1000;
    end
    pend = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) pend[0] = 1'b1;
      run_op(0, 4'b0000);
      chk("rr_id", {30'h0, last_id}, 32'(k % NREQ));
      chk("rr_p", last_p, 32'((k % NREQ) + 1) * 32'h1000);
    end

    // Operand extremes.
    a_m[2] = 16'hFFFF;
    b_m[2] = 16'hFFFF;
    pend = 4'b0100;
    run_op(0, 4'b0000);
    chk("max_p", last_p, 32'hFFFE_0001);
    a_m[3] = 16'h0000;
    b_m[3] = 16'hABCD;
    pend = 4'b1000;
    run_op(0, 4'b0000);
    chk("zero_p", last_p, 32'd0);

    // Consumer stalls for 10 cycles, then the pointer decides the next grant.
    a_m[0] = 16'd7;
    b_m[0] = 16'd9;
    a_m[2] = 16'h0102;
    b_m[2] = 16'h0304;
    pend = 4'b1101;
    run_op(10, 4'b0000);
    chk("stall_id", {30'h0, last_id}, 32'd0);
    run_op(0, 4'b0000);
    chk("after_stall_id", {30'h0, last_id}, 32'd2);
    run_op(0, 4'b0000);

    // Reset in the middle of WAIT discards the operation.
    a_m[1] = 16'h1234;
    b_m[1] = 16'h0002;
    pend = 4'b0010;
    drive();
    #1;
    chk("abort_grant", {28'h0, bus.req_ready}, 32'd2);
    @(posedge clk);
    @(negedge clk);
    pend = '0;
    drive();
    #1;
    chk("abort_busy", {31'h0, bus.busy}, 32'd1);
    rst = 1'b1;
    ptr_m = 0;
    #1;
    chk("abort_valid", {31'h0, bus.res_valid}, 32'd0);
    chk("abort_busy0", {31'h0, bus.busy}, 32'd0);
    chk("abort_p", bus.res_p, 32'd0);
    chk("abort_id", {30'h0, bus.res_id}, 32'd0);
    chk("abort_mul_a", {16'h0, bus.mul_a}, 32'd0);
    chk("abort_mul_b", {16'h0, bus.mul_b}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      chk("post_abort_valid", {31'h0, bus.res_valid}, 32'd0);
      chk("post_abort_busy", {31'h0, bus.busy}, 32'd0);
    end

    // Lowest valid index wins after reset; requester 2 withdraws and is skipped.
    for (int i = 1; i < NREQ; i++) begin
      a_m[i] = 16'(100 + i);
      b_m[i] = 16'(3 * i);
    end
    pend = 4'b1110;
    run_op(0, 4'b0100);
    chk("skip_first_id", {30'h0, last_id}, 32'd1);
    run_op(0, 4'b0000);
    chk("skip_next_id", {30'h0, last_id}, 32'd3);

    // Randomized traffic against the model.
    for (int it = 0; it < 40; it++) begin
      logic [NREQ-1:0] drop_r;
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i] = 1'b1;
          a_m[i] = rand_op();
          b_m[i] = rand_op();
        end
      end
      if (pend == '0) begin
        pend[0] = 1'b1;
        a_m[0] = rand_op();
        b_m[0] = rand_op();
      end
      drop_r = ($urandom_range(0, 5) == 0) ? NREQ'(1) << $urandom_range(0, NREQ-1) : '0;
      run_op($urandom_range(0, 3), drop_r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mult_share_ctrl.md
Name: mult_share_ctrl

Overview:
- Time-shares one combinational 16x16 multiplier (16-bit A/B, 32-bit P) between NREQ requesters.
- Arbitrates requesters round-robin and holds the winner's operands stable for MC_CYCLES cycles, because the adder tree is a multicycle path.
- Registers the 32-bit product and returns it, tagged with the requester index, over a valid/ready result port.
- Sits directly beside the multiplier instance; mul_a/mul_b drive its A/B inputs and mul_p receives its P output.

Parameters:
NREQ, 4, number of requesters (2..16)
MC_CYCLES, 2, cycles operands are held before P is sampled (>=1)
IDW, 2, width of requester tag, must equal clog2(NREQ)

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  NREQ  per-requester operation request
req_ready  output  NREQ  per-requester accept, one-hot or zero
req_a  input  16*NREQ  operand A, requester i at bits [16i+15:16i]
req_b  input  16*NREQ  operand B, same packing
mul_a  output  16  to multiplier A
mul_b  output  16  to multiplier B
mul_p  input  32  from multiplier P
res_valid  output  1  result available
res_ready  input  1  result consumer accept
res_p  output  32  registered product
res_id  output  IDW  index of requester that issued the operation
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (asynchronous, any time, including mid-operation): state=IDLE, rr_ptr=0, op_a=op_b=0, mul_a=mul_b=0, res_p=0, res_id=0, res_valid=0, busy=0, req_ready=0, wait counter=0. Any in-flight operation is discarded and produces no result.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - Winner g is the first index with req_valid set, searching rr_ptr, rr_ptr+1, ... and wrapping modulo NREQ.
  - req_ready[g]=1 combinationally; all other req_ready bits are 0. If no request is valid, req_ready=0 and the FSM stays in IDLE.
  - On the edge where req_valid[g] & req_ready[g]: op_a<=req_a[g], op_b<=req_b[g], res_id<=g, rr_ptr<=(g+1) mod NREQ, cnt<=MC_CYCLES-1, state<=WAIT.
- WAIT:
  - req_ready=0.
  - mul_a=op_a and mul_b=op_b; these come straight from registers and are stable for the whole operation.
  - cnt decrements each cycle while nonzero.
  - On the edge with cnt==0: res_p<=mul_p, res_valid<=1, state<=DONE.
- DONE:
  - res_valid=1. res_p and res_id are held stable until the handshake.
  - req_ready=0; new requests wait.
  - On the edge with res_ready=1: res_valid<=0, state<=IDLE.
  - No new grant is issued in the same cycle as the result handshake.
- Latency: accept at edge k, then res_valid=1 after edge k+MC_CYCLES. Minimum issue interval is MC_CYCLES+2 cycles.
- Requesters must hold req_valid and their operands until they see req_ready. Deasserting req_valid before grant is legal: that requester is simply skipped.
- Simultaneous requests: only one is granted per operation. rr_ptr guarantees each continuously requesting source is served within NREQ operations.
- rr_ptr wraps from NREQ-1 back to 0.
- Arithmetic: unsigned. res_p is exactly the 32-bit mul_p sampled at the end of WAIT; there is no truncation or sign handling.
- Operands 0 or 0xFFFF are not special-cased.
- res_ready held low indefinitely keeps the FSM in DONE with all outputs frozen.

Test Plan:
- After reset, req_valid=4'b0001, A0=3, B0=5 -> req_ready=0001 for one cycle, busy=1; with MC_CYCLES=2, res_valid rises 2 edges after accept with res_p=15, res_id=0.
- All four valid (A_i=i+1, B_i=0x1000) with res_ready=1 -> grants in order 0,1,2,3,0, with res_p=0x1000,0x2000,0x3000,0x4000,0x1000; issue interval is 4 cycles.
- A=0xFFFF, B=0xFFFF -> res_p=0xFFFE0001; A=0, B=0xABCD -> res_p=0.
- Hold res_ready=0 for 10 cycles after res_valid -> res_valid, res_p and res_id stay constant, req_ready=0 throughout, busy=1; release res_ready -> IDLE and the next grant follows the pointer.
- Assert rst during WAIT -> all outputs 0 immediately (asynchronous); no result ever appears for the aborted operation; the first grant after reset goes to the lowest valid index.
- Requester 2 drops req_valid before its turn while 1 and 3 keep requesting -> grant order after 1 is 3, and requester 2 is skipped.
